// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared UART constants and the receiver state encoding.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_rx
// Brief  : Mid-bit-sampling 8N1 UART receiver with a one-entry valid/ready
//          holding register, framing-error and overrun pulses.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int            CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  uart_state_e               state_q, state_d;
  logic [1:0]                sync_q, sync_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bitcnt_q, bitcnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      deliver;
  logic                      rx_s;

  // Two-flop synchronizer; presets to the idle-high line level.
  assign rx_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], rx};
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d             = '0;
          shift_d[bitcnt_q] = rx_s;
          bitcnt_d          = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        // Hold here until the line returns high so a stuck-low line cannot retrigger.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_uart_rx
// Brief  : Directed bench for uart_rx with a timestamp-based frame model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  bit chk_en = 1'b0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: the line as seen two edges late, with sample points at t0+H+k*N.
  int         cyc = 0;
  int         m_t0 = 0;
  bit         m_active = 1'b0;
  bit         m_break = 1'b0;
  logic       m_s1 = 1'b1;
  logic       m_s2 = 1'b1;
  logic [7:0] m_shift = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  always @(posedge clk) begin
    logic rs;
    int   el;
    int   k;
    bit   dlv;
    rs     = m_s2;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    dlv    = 1'b0;
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_active = 1'b0; m_break = 1'b0;
      m_data = 8'h00; m_valid = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = rx;
      if (m_break) begin
        if (rs) m_break = 1'b0;
      end else if (!m_active) begin
        if (!rs) begin
          m_active = 1'b1;
          m_t0     = cyc;
        end
      end else begin
        el = cyc - m_t0;
        if (el == H) begin
          if (rs) m_active = 1'b0;
        end else if (el > H && ((el - H) % N) == 0) begin
          k = (el - H) / N;
          if (k <= 8) begin
            m_shift[k-1] = rs;
          end else begin
            m_active = 1'b0;
            if (rs) dlv = 1'b1;
            else begin
              m_ferr  = 1'b1;
              m_break = 1'b1;
            end
          end
        end
      end
      if (dlv) begin
        if (!m_valid || rx_ready) begin
          m_data  = m_shift;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_valid", rx_valid, m_valid);
      check("rx_data", rx_data, m_data);
      check("frame_err", frame_err, m_ferr);
      check("overrun", overrun, m_ovr);
      check("busy", busy, m_active || m_break);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = stop;
    repeat (N) @(negedge clk);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte: valid appears exactly one cycle after the stop sample.
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (2 + H + 9 * N) @(negedge clk);
        check("a5_valid_before", rx_valid, 1'b0);
        @(negedge clk);
        check("a5_valid_rise", rx_valid, 1'b1);
        check("a5_data", rx_data, 8'hA5);
      end
    join
    repeat (20) @(negedge clk);
    check("a5_hold", rx_valid, 1'b1);
    consume();
    check("a5_consumed", rx_valid, 1'b0);
    check("a5_data_kept", rx_data, 8'hA5);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (N) @(negedge clk);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);

    // Framing error with the line held low afterwards.
    ferr_cnt = 0;
    send_byte(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("brk_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("brk_exit", busy, 1'b0);
    check("ferr_pulses", ferr_cnt, 1);
    check("ferr_valid", rx_valid, 1'b0);
    repeat (2 * N) @(negedge clk);
    send_byte(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    check("after_ferr_valid", rx_valid, 1'b1);
    check("after_ferr_data", rx_data, 8'h11);
    consume();

    // Overrun: two back-to-back frames, nobody consuming.
    ovr_cnt = 0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_data", rx_data, 8'h01);
    check("ovr_valid", rx_valid, 1'b1);

    // Consume on the very edge the next byte is delivered.
    ovr_cnt = 0;
    fork
      send_byte(8'h02, 1'b1);
      begin
        repeat (2 + H + 9 * N) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("simul_data", rx_data, 8'h02);
    check("simul_valid", rx_valid, 1'b1);
    check("simul_no_ovr", ovr_cnt, 0);
    consume();

    // Reset in the middle of data bit 4 of 8'hFF.
    rx = 1'b0;
    repeat (N) @(negedge clk);
    rx = 1'b1;
    repeat (4 * N + 2) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (2 * N) @(negedge clk);
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    check("post_rst_valid", rx_valid, 1'b1);
    check("post_rst_data", rx_data, 8'h5A);
    consume();
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
